// File: rtl/usb_rx_bit_timer.sv
// USB full-speed receive bit timer: per-bit phase counter resynchronised on D+ falling edges,
// mid-bit sampling, NRZI decode and bit-unstuffing feeding the RX shift register.
module usb_rx_bit_timer #(
  parameter int CLKS_PER_BIT = 8,
  parameter int SAMPLE_POINT = 3,
  parameter int STUFF_LIMIT  = 6
) (
  input  logic clk,
  input  logic n_rst,
  input  logic d_edge,
  input  logic d_plus_sync,
  input  logic rcving,
  input  logic eop,
  output logic shift_enable,
  output logic rx_bit,
  output logic byte_received,
  output logic stuff_error
);

  localparam int PW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int OW = $clog2(STUFF_LIMIT + 1);

  localparam logic [PW-1:0] PHASE_MAX    = PW'(CLKS_PER_BIT - 1);
  localparam logic [PW-1:0] PHASE_SAMPLE = PW'(SAMPLE_POINT);
  localparam logic [PW-1:0] PHASE_ONE    = PW'(1);
  localparam logic [OW-1:0] ONES_MAX     = OW'(STUFF_LIMIT);
  localparam logic [OW-1:0] ONES_ONE     = OW'(1);

  logic [PW-1:0] phase, phase_next;
  logic [2:0]    bit_cnt, bit_cnt_next;
  logic [OW-1:0] ones_cnt, ones_next;
  logic          prev_level, prev_next;
  logic          shift_next, rx_bit_next, byte_next, err_next;
  logic          sample, dec;

  // The edge cycle itself counts as phase 0, so a resync loads 1 and suppresses that cycle's sample.
  always_comb begin
    phase_next   = phase;
    bit_cnt_next = bit_cnt;
    ones_next    = ones_cnt;
    prev_next    = prev_level;
    shift_next   = 1'b0;
    rx_bit_next  = rx_bit;
    byte_next    = 1'b0;
    err_next     = 1'b0;
    sample       = 1'b0;
    dec          = ~(d_plus_sync ^ prev_level);

    if (!rcving || eop) begin
      phase_next   = '0;
      bit_cnt_next = '0;
      ones_next    = '0;
      prev_next    = 1'b1;
    end else if (d_edge) begin
      phase_next = PHASE_ONE;
    end else begin
      phase_next = (phase == PHASE_MAX) ? '0 : phase + PHASE_ONE;
      sample     = (phase == PHASE_SAMPLE);
    end

    if (sample) begin
      prev_next = d_plus_sync;
      if (ones_cnt == ONES_MAX) begin
        ones_next = '0;
        err_next  = dec;
      end else begin
        shift_next   = 1'b1;
        rx_bit_next  = dec;
        ones_next    = dec ? ones_cnt + ONES_ONE : '0;
        bit_cnt_next = bit_cnt + 3'd1;
        byte_next    = (bit_cnt == 3'd7);
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      phase         <= '0;
      bit_cnt       <= '0;
      ones_cnt      <= '0;
      prev_level    <= 1'b1;
      shift_enable  <= 1'b0;
      rx_bit        <= 1'b0;
      byte_received <= 1'b0;
      stuff_error   <= 1'b0;
    end else begin
      phase         <= phase_next;
      bit_cnt       <= bit_cnt_next;
      ones_cnt      <= ones_next;
      prev_level    <= prev_next;
      shift_enable  <= shift_next;
      rx_bit        <= rx_bit_next;
      byte_received <= byte_next;
      stuff_error   <= err_next;
    end
  end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Bench for usb_rx_bit_timer: a table of bit-period records (line level, length, expected
// pulses and their offset inside the period) plus a hand sequence for asynchronous reset.
module tb_usb_rx_bit_timer;

  logic clk = 1'b0;
  logic n_rst, d_edge, d_plus_sync, rcving, eop;
  logic shift_enable, rx_bit, byte_received, stuff_error;
  logic prev_line = 1'b1;

  int pass_cnt = 0;
  int check_cnt = 0;

  typedef struct {
    logic rcv;
    logic eop;
    logic level;
    int   period;
    int   exp_se;
    int   exp_bit;
    int   exp_off;
    int   exp_byte;
    int   exp_err;
  } vec_t;

  vec_t vecs[$];

  int drift_lvl[16] = '{0, 1, 1, 0, 0, 1, 0, 0, 1, 0, 1, 0, 0, 1, 0, 0};
  int drift_bit[16] = '{0, 0, 1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 1};
  int drift_off[16] = '{3, 4, 3, 3, 2, 3, 3, 4, 3, 3, 2, 3, 2, 3, 3, 4};

  always #5 clk = ~clk;

  usb_rx_bit_timer dut (
    .clk(clk),
    .n_rst(n_rst),
    .d_edge(d_edge),
    .d_plus_sync(d_plus_sync),
    .rcving(rcving),
    .eop(eop),
    .shift_enable(shift_enable),
    .rx_bit(rx_bit),
    .byte_received(byte_received),
    .stuff_error(stuff_error)
  );

  // One clock of line activity; d_edge mimics the upstream falling-edge detector.
  task automatic applyStimulus(input logic rcv, input logic e, input logic level);
    rcving      = rcv;
    eop         = e;
    d_plus_sync = level;
    d_edge      = prev_line & ~level;
    prev_line   = level;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input int idx, input int actual, input int expected);
    check_cnt++;
    if (actual == expected) pass_cnt++;
    else $display("[TB] FAIL %s (rec %0d): got %0d, expected %0d", name, idx, actual, expected);
  endtask

  task automatic addRec(input logic rcv, input logic e, input logic level, input int period,
                        input int se, input int b, input int off, input int byt, input int err);
    vec_t v;
    v.rcv = rcv; v.eop = e; v.level = level; v.period = period;
    v.exp_se = se; v.exp_bit = b; v.exp_off = off; v.exp_byte = byt; v.exp_err = err;
    vecs.push_back(v);
  endtask

  task automatic addIdle();
    addRec(1'b0, 1'b0, 1'b1, 4, 0, 0, -1, 0, 0);
  endtask

  task automatic addBit(input logic level, input int period, input int b, input int off, input int byt);
    addRec(1'b1, 1'b0, level, period, 1, b, off, byt, 0);
  endtask

  task automatic addSync();
    for (int k = 0; k < 7; k++) addBit(logic'(k % 2), 8, 0, 3, 0);
    addBit(1'b0, 8, 1, 3, 1);
  endtask

  initial begin
    int se_cnt, se_off, se_bit, byte_cnt, err_cnt, err_off, any_out;

    // Packet SYNC KJKJKJKK
    addIdle();
    addSync();
    addIdle();
    // Six 1s, stuffed 0, then a real 0 (8th shifted bit)
    addIdle();
    addBit(1'b0, 8, 0, 3, 0);
    for (int k = 0; k < 6; k++) addBit(1'b0, 8, 1, 3, 0);
    addRec(1'b1, 1'b0, 1'b1, 8, 0, 0, -1, 0, 0);
    addBit(1'b0, 8, 0, 3, 1);
    addIdle();
    // Seven 1s: the seventh is a stuff violation
    addIdle();
    addBit(1'b0, 8, 0, 3, 0);
    for (int k = 0; k < 6; k++) addBit(1'b0, 8, 1, 3, 0);
    addRec(1'b1, 1'b0, 1'b0, 8, 0, 0, 3, 0, 1);
    addIdle();
    // Drift: alternating 7/9-clock bits
    addIdle();
    for (int k = 0; k < 16; k++)
      addBit(logic'(drift_lvl[k]), (k % 2 == 0) ? 7 : 9, drift_bit[k], drift_off[k], (k == 7 || k == 15) ? 1 : 0);
    addIdle();
    // EOP after 5 bits discards the partial byte; next packet restarts the byte count
    addIdle();
    for (int k = 0; k < 5; k++) addBit(logic'(k % 2), 8, 0, 3, 0);
    addRec(1'b1, 1'b1, 1'b0, 8, 0, 0, -1, 0, 0);
    addIdle();
    addSync();
    addIdle();

    n_rst = 1'b0; rcving = 1'b0; eop = 1'b0; d_plus_sync = 1'b1; d_edge = 1'b0;
    #1;
    checkOutput("reset_shift_enable", -1, int'(shift_enable), 0);
    checkOutput("reset_byte_received", -1, int'(byte_received), 0);
    checkOutput("reset_stuff_error", -1, int'(stuff_error), 0);
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b1);

    // Asynchronous reset while a shift pulse is on the outputs, one bit into a byte
    for (int j = 0; j < 4; j++) applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("pre_reset_shift_enable", -1, int'(shift_enable), 1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async_reset_shift_enable", -1, int'(shift_enable), 0);
    checkOutput("async_reset_rx_bit", -1, int'(rx_bit), 0);
    checkOutput("async_reset_byte_received", -1, int'(byte_received), 0);
    checkOutput("async_reset_stuff_error", -1, int'(stuff_error), 0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    n_rst = 1'b1;
    any_out = 0;
    for (int j = 0; j < 12; j++) begin
      applyStimulus(1'b0, 1'b0, 1'b1);
      if (shift_enable || byte_received || stuff_error) any_out++;
    end
    checkOutput("idle_after_reset_pulses", -1, any_out, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      se_cnt = 0; se_off = -1; se_bit = -1; byte_cnt = 0; err_cnt = 0; err_off = -1;
      for (int j = 0; j < vecs[i].period; j++) begin
        applyStimulus(vecs[i].rcv, vecs[i].eop, vecs[i].level);
        if (shift_enable) begin
          se_cnt++;
          se_off = j;
          se_bit = int'(rx_bit);
        end
        if (byte_received) byte_cnt++;
        if (stuff_error) begin
          err_cnt++;
          err_off = j;
        end
      end
      checkOutput("shift_count", i, se_cnt, vecs[i].exp_se);
      if (vecs[i].exp_se > 0) begin
        checkOutput("rx_bit", i, se_bit, vecs[i].exp_bit);
        checkOutput("shift_offset", i, se_off, vecs[i].exp_off);
      end
      checkOutput("byte_count", i, byte_cnt, vecs[i].exp_byte);
      checkOutput("stuff_error_count", i, err_cnt, vecs[i].exp_err);
      if (vecs[i].exp_err > 0) checkOutput("stuff_error_offset", i, err_off, vecs[i].exp_off);
    end

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
